// File: rtl/beta_reg_file_pkg.sv
// Shared constants and FSM encoding for the beta_reg_file register file.
package beta_reg_file_pkg;

  localparam int unsigned DEF_WID_DATA = 32;
  localparam int unsigned DEF_WID_ADDR = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_ZERO_IDX = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/beta_reg_file_clear_seq.sv
// Post-reset clear sequencer: walks entries 0..2**WID_ADDR-2 writing zero, then idles in RUN.
module reg_clear_seq
  import beta_reg_file_pkg::*;
#(
  parameter int unsigned WID_ADDR = DEF_WID_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,
  output logic [WID_ADDR-1:0] clr_addr,
  output logic                clr_we
);

  localparam logic [WID_ADDR-1:0] LAST_IDX = {{(WID_ADDR-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [WID_ADDR-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = RUN;
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/beta_reg_file.sv
// Beta 32-entry register file: 2 enable-gated registered read ports, 1 write port, R31 reads zero.
// Optional write-through forwarding to the read ports under `REG_FILE_BYPASS_EN.
module beta_reg_file
  import beta_reg_file_pkg::*;
#(
  parameter int unsigned WID_DATA = DEF_WID_DATA,
  parameter int unsigned WID_ADDR = DEF_WID_ADDR
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic                Busy,
  input  logic                RdEnA,
  input  logic [WID_ADDR-1:0] RdAddrA,
  output logic [WID_DATA-1:0] RdDataA,
  input  logic                RdEnB,
  input  logic [WID_ADDR-1:0] RdAddrB,
  output logic [WID_DATA-1:0] RdDataB,
  input  logic                WrEn,
  input  logic [WID_ADDR-1:0] WrAddr,
  input  logic [WID_DATA-1:0] WrData
);

  localparam int unsigned NUM_SLOTS = (WID_ADDR == DEF_WID_ADDR) ? NUM_REGS : (2**WID_ADDR);
  localparam int unsigned ZERO_INT  = (WID_ADDR == DEF_WID_ADDR) ? REG_ZERO_IDX : (NUM_SLOTS - 1);
  localparam logic [WID_ADDR-1:0] ZERO_IDX = WID_ADDR'(ZERO_INT);

  logic [WID_DATA-1:0] mem_q [ZERO_INT];
  logic [WID_DATA-1:0] mem_d [ZERO_INT];
  logic [WID_DATA-1:0] rd_data_a_q, rd_data_a_d;
  logic [WID_DATA-1:0] rd_data_b_q, rd_data_b_d;

  logic                busy;
  logic [WID_ADDR-1:0] clr_addr;
  logic                clr_we;
  logic                wr_en_eff;
  logic [WID_ADDR-1:0] wr_addr_eff;
  logic [WID_DATA-1:0] wr_data_eff;
  logic                user_wr;

  reg_clear_seq #(.WID_ADDR(WID_ADDR)) u_clear_seq (
    .clk      (Clock),
    .rst      (Reset),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // The clear sequencer owns the write port while busy; user writes to R31 are dropped.
  assign user_wr     = WrEn && !busy && !Reset && (WrAddr != ZERO_IDX);
  assign wr_en_eff   = busy ? clr_we : user_wr;
  assign wr_addr_eff = busy ? clr_addr : WrAddr;
  assign wr_data_eff = busy ? '0 : WrData;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_eff && (wr_addr_eff != ZERO_IDX)) mem_d[wr_addr_eff] = wr_data_eff;
  end

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (Reset) begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
    end else begin
      if (RdEnA) begin
        if (busy || (RdAddrA == ZERO_IDX)) rd_data_a_d = '0;
`ifdef REG_FILE_BYPASS_EN
        else if (user_wr && (WrAddr == RdAddrA)) rd_data_a_d = WrData;
`endif
        else rd_data_a_d = mem_q[RdAddrA];
      end
      if (RdEnB) begin
        if (busy || (RdAddrB == ZERO_IDX)) rd_data_b_d = '0;
`ifdef REG_FILE_BYPASS_EN
        else if (user_wr && (WrAddr == RdAddrB)) rd_data_b_d = WrData;
`endif
        else rd_data_b_d = mem_q[RdAddrB];
      end
    end
  end

  always_ff @(posedge Clock) begin
    mem_q       <= mem_d;
    rd_data_a_q <= rd_data_a_d;
    rd_data_b_q <= rd_data_b_d;
  end

  assign Busy    = busy;
  assign RdDataA = rd_data_a_q;
  assign RdDataB = rd_data_b_q;

endmodule

// File: tb/tb_beta_reg_file.sv
// Directed self-checking bench for beta_reg_file (vector table plus clear/reset sequences).
module tb_beta_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Busy;
  logic        RdEnA, RdEnB, WrEn;
  logic [4:0]  RdAddrA, RdAddrB, WrAddr;
  logic [31:0] RdDataA, RdDataB, WrData;

  int n_checks = 0;
  int n_fail   = 0;

  beta_reg_file #(.WID_DATA(32), .WID_ADDR(5)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Busy    (Busy),
    .RdEnA   (RdEnA),
    .RdAddrA (RdAddrA),
    .RdDataA (RdDataA),
    .RdEnB   (RdEnB),
    .RdAddrB (RdAddrB),
    .RdDataB (RdDataB),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        en_a;
    logic [4:0]  addr_a;
    logic        en_b;
    logic [4:0]  addr_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (Busy && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'd31);
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ea, input logic [4:0] aa,
                              input logic eb, input logic [4:0] ab,
                              input logic [31:0] xa, input logic [31:0] xb);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.en_a = ea; v.addr_a = aa; v.en_b = eb; v.addr_b = ab;
    v.exp_a = xa; v.exp_b = xb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  0, 5'd0,  32'h0, 32'h0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  0, 5'd0,  32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd6,  0, 5'd0,  32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1, 5'd31, 32'h12345678, 0, 5'd0,  0, 5'd0,  32'hDEADBEEF, 32'h0);
    vecs[4]  = mk(0, 5'd0,  32'h0,        1, 5'd31, 1, 5'd31, 32'h0, 32'h0);
    vecs[5]  = mk(1, 5'd7,  32'h11,       0, 5'd0,  0, 5'd0,  32'h0, 32'h0);
    vecs[6]  = mk(1, 5'd7,  32'h22,       0, 5'd0,  1, 5'd7,  32'h0, BYP ? 32'h22 : 32'h11);
    vecs[7]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd7,  32'h0, 32'h22);
    vecs[8]  = mk(1, 5'd1,  32'h1,        0, 5'd0,  0, 5'd0,  32'h0, 32'h22);
    vecs[9]  = mk(1, 5'd2,  32'h2,        0, 5'd0,  0, 5'd0,  32'h0, 32'h22);
    vecs[10] = mk(0, 5'd0,  32'h0,        1, 5'd1,  1, 5'd2,  32'h1, 32'h2);
    vecs[11] = mk(0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    vecs[12] = mk(1, 5'd5,  32'h55,       1, 5'd5,  1, 5'd1,  BYP ? 32'h55 : 32'hDEADBEEF, 32'h1);

    Reset = 1'b1; RdEnA = 0; RdEnB = 0; WrEn = 0;
    RdAddrA = '0; RdAddrB = '0; WrAddr = '0; WrData = '0;
    step();
    chk("reset_busy", 32'(Busy), 32'd1);
    chk("reset_rda", RdDataA, 32'h0);
    chk("reset_rdb", RdDataB, 32'h0);
    Reset = 1'b0;
    count_busy("clear_len");

    RdEnA = 1'b1;
    for (int i = 0; i < 31; i++) begin
      RdAddrA = 5'(i);
      step();
      chk($sformatf("clear_r%0d", i), RdDataA, 32'h0);
    end
    RdEnA = 1'b0;

    for (int i = 0; i < 13; i++) begin
      WrEn = vecs[i].wr_en; WrAddr = vecs[i].wr_addr; WrData = vecs[i].wr_data;
      RdEnA = vecs[i].en_a; RdAddrA = vecs[i].addr_a;
      RdEnB = vecs[i].en_b; RdAddrB = vecs[i].addr_b;
      step();
      chk($sformatf("vec%0d_a", i), RdDataA, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), RdDataB, vecs[i].exp_b);
    end
    WrEn = 0; RdEnA = 0; RdEnB = 0;

    // Write-through outcome must not leak into storage: R5 now holds 0x55 in both builds.
    RdEnA = 1; RdAddrA = 5'd5;
    step();
    chk("r5_after_wr", RdDataA, 32'h55);
    RdEnA = 0;

    // Restart the clear part-way through, then try to write during the clear.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (10) step();
    chk("midclear_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    step();
    chk("rerst_busy", 32'(Busy), 32'd1);
    chk("rerst_rda", RdDataA, 32'h0);
    Reset = 1'b0;
    WrEn = 1; WrAddr = 5'd3; WrData = 32'hAA;
    count_busy("reclear_len");
    WrEn = 0;
    RdEnA = 1; RdAddrA = 5'd3;
    RdEnB = 1; RdAddrB = 5'd7;
    step();
    chk("r3_ignored", RdDataA, 32'h0);
    chk("r7_recleared", RdDataB, 32'h0);
    RdAddrA = 5'd30; RdAddrB = 5'd5;
    step();
    chk("r30_recleared", RdDataA, 32'h0);
    chk("r5_recleared", RdDataB, 32'h0);
    RdEnA = 0; RdEnB = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
